// File: rtl/integral_window_reader_if.sv
// Pixel-side and window-side signals of the integral window reader.
// The bench drives through master; the reader uses slave.
interface integral_window_reader_if #(
  parameter int DW = 16
);
  logic          i_frame_start;
  logic          i_valid;
  logic [DW-1:0] i_tl;
  logic [DW-1:0] i_tr;
  logic [DW-1:0] i_bl;
  logic [DW-1:0] i_br;
  logic          o_valid;
  logic [DW-1:0] o_window_sum;
  logic [11:0]   o_x;
  logic [11:0]   o_y;
  logic          o_frame_end;
  logic          o_busy;

  modport master (
    output i_frame_start, i_valid, i_tl, i_tr, i_bl, i_br,
    input  o_valid, o_window_sum, o_x, o_y, o_frame_end, o_busy
  );

  modport slave (
    input  i_frame_start, i_valid, i_tl, i_tr, i_bl, i_br,
    output o_valid, o_window_sum, o_x, o_y, o_frame_end, o_busy
  );
endinterface

// File: rtl/integral_window_reader.sv
// Streams integral-image corner values and emits one square-window sum per
// window-valid pixel, two cycles after the pixel is accepted.
module integral_window_reader #(
  parameter int DATA_WIDTH_16       = 16,
  parameter int INTEGRAL_WIDTH      = 3,
  parameter int FRAME_CAMERA_WIDTH  = 10,
  parameter int FRAME_CAMERA_HEIGHT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  integral_window_reader_if.slave bus
);
  localparam int          DW   = DATA_WIDTH_16;
  localparam logic [11:0] X_LAST = 12'(FRAME_CAMERA_WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(FRAME_CAMERA_HEIGHT - 1);
  localparam logic [11:0] W_OFF  = 12'(INTEGRAL_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t          r_state;
  logic [11:0]     r_x, r_y;
  logic [1:0]      r_vld_pipe;
  logic [DW-1:0]   r_d1, r_d2;
  logic [11:0]     r_x1, r_y1;
  logic            r_fe1;
  logic [DW-1:0]   r_sum;
  logic [11:0]     r_ox, r_oy;
  logic            r_fe;

  logic            w_run, w_accept, w_win, w_last;
  logic [11:0]     w_px, w_py;

  // A frame start always re-bases the position, so a coincident pixel is (0,0).
  assign w_run    = (r_state == FILL) || (r_state == STREAM);
  assign w_accept = bus.i_valid && (bus.i_frame_start || w_run);
  assign w_px     = bus.i_frame_start ? 12'd0 : r_x;
  assign w_py     = bus.i_frame_start ? 12'd0 : r_y;
  assign w_win    = w_accept && (w_px >= W_OFF) && (w_py >= W_OFF);
  assign w_last   = w_accept && (w_px == X_LAST) && (w_py == Y_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_vld_pipe <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_fe1      <= 1'b0;
      r_sum      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_fe       <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_px == X_LAST) begin
          r_x <= '0;
          r_y <= w_last ? 12'd0 : w_py + 12'd1;
        end else begin
          r_x <= w_px + 12'd1;
          r_y <= w_py;
        end
      end else if (bus.i_frame_start) begin
        r_x <= '0;
        r_y <= '0;
      end

      if (bus.i_frame_start) begin
        r_state <= w_last ? DONE : (w_win ? STREAM : FILL);
      end else begin
        case (r_state)
          IDLE:    r_state <= IDLE;
          FILL:    r_state <= w_last ? DONE : (w_win ? STREAM : FILL);
          STREAM:  r_state <= w_last ? DONE : STREAM;
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end

      // Stage 1: column differences; stage 2: their difference, modulo 2^DW.
      r_vld_pipe <= {r_vld_pipe[0], w_win};
      r_fe1      <= w_last;
      r_fe       <= r_fe1;
      if (w_win) begin
        r_d1 <= bus.i_br - bus.i_tr;
        r_d2 <= bus.i_bl - bus.i_tl;
        r_x1 <= w_px - W_OFF;
        r_y1 <= w_py - W_OFF;
      end
      if (r_vld_pipe[0]) begin
        r_sum <= r_d1 - r_d2;
        r_ox  <= r_x1;
        r_oy  <= r_y1;
      end
    end
  end

  assign bus.o_valid      = r_vld_pipe[1];
  assign bus.o_window_sum = r_sum;
  assign bus.o_x          = r_ox;
  assign bus.o_y          = r_oy;
  assign bus.o_frame_end  = r_fe;
  assign bus.o_busy       = (r_state != IDLE);
endmodule

// File: tb/tb_integral_window_reader.sv
// Directed bench: the driver queues expected windows, a negedge monitor checks them.
module tb_integral_window_reader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  integral_window_reader_if #(.DW(16)) bus();

  integral_window_reader #(
    .DATA_WIDTH_16(16), .INTEGRAL_WIDTH(3),
    .FRAME_CAMERA_WIDTH(10), .FRAME_CAMERA_HEIGHT(10)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int          due;
    logic [15:0] sum;
    logic [11:0] x;
    logic [11:0] y;
    logic        fe;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0, seen = 0;
  int mx = 0, my = 0, s0 = 0;
  bit mact = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid) begin
      seen++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d sum=%0d x=%0d y=%0d", cyc, bus.o_window_sum, bus.o_x, bus.o_y);
      end else begin
        me = q.pop_front();
        if (me.due != cyc || bus.o_window_sum !== me.sum || bus.o_x !== me.x ||
            bus.o_y !== me.y || bus.o_frame_end !== me.fe) begin
          bad++;
          $display("FAIL window cyc=%0d got sum=%0d x=%0d y=%0d fe=%0d want cyc=%0d sum=%0d x=%0d y=%0d fe=%0d",
                   cyc, bus.o_window_sum, bus.o_x, bus.o_y, bus.o_frame_end,
                   me.due, me.sum, me.x, me.y, me.fe);
        end
      end
    end else begin
      if (bus.o_frame_end !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL frame_end_without_valid cyc=%0d got=%0d want=0", cyc, bus.o_frame_end);
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_valid cyc=%0d got=0 want=1 (sum=%0d x=%0d y=%0d)", cyc, q[0].sum, q[0].x, q[0].y);
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  // One cycle of stimulus; queues the window the pixel should produce, if any.
  task automatic px(input bit fs, input bit v, input logic [15:0] tl, input logic [15:0] tr,
                    input logic [15:0] bl, input logic [15:0] br,
                    input bit ovr = 1'b0, input logic [15:0] osum = 16'd0);
    exp_t e;
    @(posedge clk);
    #1;
    bus.i_frame_start = fs;
    bus.i_valid       = v;
    bus.i_tl = tl; bus.i_tr = tr; bus.i_bl = bl; bus.i_br = br;
    if (fs) begin
      mx = 0; my = 0; mact = 1'b1;
    end
    if (v && mact) begin
      if (mx >= 2 && my >= 2) begin
        e.due = cyc + 2;
        e.sum = ovr ? osum : 16'((br - tr) - (bl - tl));
        e.x   = 12'(mx - 2);
        e.y   = 12'(my - 2);
        e.fe  = (mx == 9 && my == 9);
        q.push_back(e);
      end
      if (mx == 9 && my == 9) mact = 1'b0;
      if (mx == 9) begin
        mx = 0; my++;
      end else mx++;
    end
  endtask

  task automatic pxk(input bit fs, input bit v, input int k);
    px(fs, v, 16'(3 * k), 16'(7 * k), 16'(11 * k), 16'(50 * k + 1000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.i_frame_start = 1'b0;
    bus.i_valid       = 1'b1;
    bus.i_tl = 16'd1; bus.i_tr = 16'd2; bus.i_bl = 16'd3; bus.i_br = 16'd4;

    // Reset held low with i_valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", int'(bus.o_valid), 0);
      chk("rst_busy", int'(bus.o_busy), 0);
      chk("rst_sum", int'(bus.o_window_sum), 0);
      chk("rst_xy", int'({bus.o_x, bus.o_y}), 0);
      chk("rst_fe", int'(bus.o_frame_end), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.i_valid = 1'b0;

    // Frame 1: start pulse alone, then 100 contiguous pixels
    s0 = seen;
    px(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    pxk(1'b0, 1'b1, 1);
    @(negedge clk);
    chk("busy_after_start", int'(bus.o_busy), 1);
    for (int k = 2; k <= 100; k++) pxk(1'b0, 1'b1, k);
    pxk(1'b0, 1'b1, 101);
    @(negedge clk);
    chk("busy_in_done", int'(bus.o_busy), 1);
    pxk(1'b0, 1'b1, 102);
    @(negedge clk);
    chk("busy_fell", int'(bus.o_busy), 0);
    for (int k = 103; k <= 106; k++) pxk(1'b0, 1'b1, k);
    repeat (3) px(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("frame_window_count", seen - s0, 64);
    chk("frame_queue_empty", q.size(), 0);

    // Frame 2: start coincident with pixel 1, hand-computed sums at pixels 23/24
    pxk(1'b1, 1'b1, 1);
    for (int k = 2; k <= 22; k++) pxk(1'b0, 1'b1, k);
    px(1'b0, 1'b1, 16'd5, 16'd20, 16'd30, 16'd100, 1'b1, 16'd55);
    px(1'b0, 1'b1, 16'd0, 16'd10, 16'd0, 16'd2, 1'b1, 16'd65528);

    // Gapped input, then restart coincident with pixel 50
    for (int k = 25; k <= 49; k++) begin
      pxk(1'b0, 1'b1, k);
      px(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    end
    pxk(1'b1, 1'b1, 200);
    for (int k = 2; k <= 39; k++) pxk(1'b0, 1'b1, 200 + k);

    // Mid-frame reset in the pixel-40 slot; in-flight windows are dropped
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    reset = 1'b1;
    mact = 1'b0;
    @(negedge clk);
    chk("midrst_sum", int'(bus.o_window_sum), 0);
    chk("midrst_busy", int'(bus.o_busy), 0);
    for (int k = 41; k <= 44; k++) pxk(1'b0, 1'b1, 300 + k);
    @(negedge clk);
    chk("idle_after_rst", int'(bus.o_busy), 0);
    repeat (3) px(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
